// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback controller:
// address/data widths, requester identifiers and a one-hot helper.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    // Identifies a writeback requester; also the encoding of the
    // round-robin pointer (which requester wins the next tie).
    typedef enum logic {
        REQ_A = 1'b0,   // ALU writeback
        REQ_B = 1'b1    // load / multicycle unit
    } req_id_t;

    // One-hot mask for a destination register. r0 is hardwired to zero,
    // so it never produces a set or clear bit.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (rd != '0) begin
            m[rd] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 of req/gnt is requester A,
// bit 1 is requester B. The pointer names the requester that wins
// when both ask; it moves to the loser after every contested grant.
module rr_arb2
    import regfile_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_t ptr;

    // Grant decode: a lone requester always wins, a tie goes to the
    // pointer; nothing is granted while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (clrn) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr == REQ_A) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer register: only a contested grant hands priority over to
    // the requester that lost; uncontested grants leave it alone.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ptr <= req_id_t'(RR_INIT);
        end else if (req == 2'b11) begin
            ptr <= gnt[0] ? REQ_B : REQ_A;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: arbitrates two writeback
// requesters onto the single register-file write port and keeps a
// pending-write scoreboard that stalls decode on RAW hazards.
//
// Handshake: a requester presents valid with rd/data; ready is a
// combinational function of both valids and the arbiter pointer and
// is never high without its own valid. A transfer happens at a rising
// edge where valid and ready are both 1; rd/data may change freely
// while valid waits, only the values at the transfer edge are used.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    input  logic                  issue_we,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] wn,
    output logic [DATA_W-1:0]     d,
    output logic                  we,
    output logic [NUM_REGS-1:0]   pending
);

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0]     sel_data;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;
    logic [NUM_REGS-1:0]   pending_next;

    assign req = {b_valid, a_valid};

    rr_arb2 #(
        .RR_INIT (RR_INIT)
    ) u_arb (
        .clk  (clk),
        .clrn (clrn),
        .req  (req),
        .gnt  (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    // Winner select: grant is one-hot or zero, so B's bit picks B.
    always_comb begin
        xfer     = gnt[0] | gnt[1];
        sel_rd   = a_rd;
        sel_data = a_data;
        if (gnt[1]) begin
            sel_rd   = b_rd;
            sel_data = b_data;
        end
    end

    // RAW hazard detect: a source read of a register with an
    // outstanding write holds decode; r0 never stalls.
    always_comb begin
        stall = 1'b0;
        if (rs != '0 && pending[rs]) begin
            stall = 1'b1;
        end
        if (rt != '0 && pending[rt]) begin
            stall = 1'b1;
        end
    end

    // Scoreboard next state: the writeback clears its bit, a fresh
    // issue sets its bit, and the set is applied last so a new issue
    // to the same register stays outstanding.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_we && !stall) begin
            set_mask = reg_mask(issue_rd);
        end
        if (xfer) begin
            clr_mask = reg_mask(sel_rd);
        end
        pending_next    = (pending & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Write-port register: a transfer produces a one-cycle write pulse;
    // writes to r0 are accepted but suppressed and wn/d keep the last
    // real write.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            we <= 1'b0;
            wn <= '0;
            d  <= '0;
        end else if (xfer && sel_rd != '0) begin
            we <= 1'b1;
            wn <= sel_rd;
            d  <= sel_data;
        end else begin
            we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl: scenario tasks drive one cycle at a
// time; expected writes are queued at the transfer edge and popped by
// a monitor on the following falling edge.
module tb_regfile_wb_ctrl;

    localparam bit RR_INIT = 1'b0;

    logic        clk;
    logic        clrn;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        stall;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        we;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {rd, data} of each expected register-file write.
    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;
    logic        mon_en = 1'b0;

    // Reference model state.
    logic        m_ptr;
    logic [31:0] m_pend;

    // Combinational outputs observed in the most recent cycle.
    logic obs_ga;
    logic obs_gb;
    logic obs_stall;

    regfile_wb_ctrl #(
        .RR_INIT (RR_INIT)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .a_valid  (a_valid),
        .a_rd     (a_rd),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_rd     (b_rd),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .issue_we (issue_we),
        .issue_rd (issue_rd),
        .rs       (rs),
        .rt       (rt),
        .stall    (stall),
        .wn       (wn),
        .d        (d),
        .we       (we),
        .pending  (pending)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Write monitor: one cycle after each queued transfer a write must
    // appear; otherwise we must be low.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                if (we !== 1'b1 || wn !== mon_exp[36:32] || d !== mon_exp[31:0]) begin
                    errors++;
                    $display("FAIL write: we=%b wn=%0d d=%h, expected we=1 wn=%0d d=%h",
                             we, wn, d, mon_exp[36:32], mon_exp[31:0]);
                end
            end else if (we !== 1'b0) begin
                errors++;
                $display("FAIL idle_we: we=%b wn=%0d d=%h, expected we=0", we, wn, d);
            end
        end
    end

    // One clock cycle: drive at the falling edge, check ready/stall,
    // advance the model at the rising edge, check pending afterwards.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
                         input logic iwe, input logic [4:0] ird,
                         input logic [4:0] irs, input logic [4:0] irt);
        logic        ga;
        logic        gb;
        logic        es;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] setm;
        logic [31:0] clrm;
        a_valid  = av;  a_rd = ard;  a_data = adat;
        b_valid  = bv;  b_rd = brd;  b_data = bdat;
        issue_we = iwe; issue_rd = ird;
        rs       = irs; rt = irt;
        #1;
        ga = clrn && av && (!bv || m_ptr == 1'b0);
        gb = clrn && bv && (!av || m_ptr == 1'b1);
        es = (irs != 0 && m_pend[irs]) || (irt != 0 && m_pend[irt]);
        obs_ga    = a_ready;
        obs_gb    = b_ready;
        obs_stall = stall;
        checks++;
        if (a_ready !== ga || b_ready !== gb) begin
            errors++;
            $display("FAIL ready: a_ready=%b b_ready=%b, expected %b %b", a_ready, b_ready, ga, gb);
        end
        checks++;
        if (stall !== es) begin
            errors++;
            $display("FAIL stall: stall=%b, expected %b (rs=%0d rt=%0d)", stall, es, irs, irt);
        end
        @(posedge clk);
        if (!clrn) begin
            m_pend = '0;
            m_ptr  = RR_INIT;
        end else begin
            wrd  = gb ? brd : ard;
            wdat = gb ? bdat : adat;
            setm = '0;
            clrm = '0;
            if (iwe && !es && ird != 0) setm[ird] = 1'b1;
            if ((ga || gb) && wrd != 0) begin
                clrm[wrd] = 1'b1;
                exp_q.push_back({wrd, wdat});
            end
            if (av && bv) m_ptr = ga ? 1'b1 : 1'b0;
            m_pend    = (m_pend & ~clrm) | setm;
            m_pend[0] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (pending !== m_pend) begin
            errors++;
            $display("FAIL pending: pending=%h, expected %h", pending, m_pend);
        end
    endtask

    task automatic idle(input logic [4:0] irs, input logic [4:0] irt);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, irs, irt);
    endtask

    task automatic test_reset();
        clrn   = 1'b0;
        m_ptr  = RR_INIT;
        m_pend = '0;
        @(negedge clk);
        cycle(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        checks++;
        if (we !== 1'b0 || wn !== 5'd0 || d !== 32'd0) begin
            errors++;
            $display("FAIL reset_wport: we=%b wn=%0d d=%h, expected 0 0 0", we, wn, d);
        end
        clrn   = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, 5'd5, 32'h11111111, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_ga !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: a_ready=%b, expected 1", obs_ga);
        end
        checks++;
        if (we !== 1'b1 || wn !== 5'd5 || d !== 32'h11111111) begin
            errors++;
            $display("FAIL single_write: we=%b wn=%0d d=%h, expected 1 5 11111111", we, wn, d);
        end
        idle(5'd0, 5'd0);
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: we=%b, expected 0", we);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 5'd3, $urandom(), 1'b1, 5'd4, $urandom(), 1'b0, 5'd0, 5'd0, 5'd0);
            checks++;
            if (obs_ga !== (i % 2 == 0) || obs_gb !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_alternate: cycle %0d a_ready=%b b_ready=%b, expected %b %b",
                         i, obs_ga, obs_gb, (i % 2 == 0), (i % 2 == 1));
            end
            checks++;
            if (we !== 1'b1 || wn !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin
                errors++;
                $display("FAIL rr_write: cycle %0d we=%b wn=%0d", i, we, wn);
            end
        end
        idle(5'd0, 5'd0);
    endtask

    task automatic test_stall();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
        for (int i = 0; i < 2; i++) begin
            idle(5'd7, 5'd0);
            checks++;
            if (obs_stall !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: stall=%b, expected 1", obs_stall);
            end
        end
        // Stalled issue to r12 must be ignored.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5_0007, 1'b1, 5'd12, 5'd0, 5'd7);
        checks++;
        if (obs_stall !== 1'b1 || obs_gb !== 1'b1) begin
            errors++;
            $display("FAIL stall_xfer: stall=%b b_ready=%b, expected 1 1", obs_stall, obs_gb);
        end
        idle(5'd7, 5'd7);
        checks++;
        if (obs_stall !== 1'b0 || pending[12] !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: stall=%b pending12=%b, expected 0 0", obs_stall, pending[12]);
        end
    endtask

    task automatic test_set_wins();
        cycle(1'b1, 5'd9, 32'h0000_0909, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
        checks++;
        if (pending[9] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: pending9=%b, expected 1", pending[9]);
        end
        cycle(1'b1, 5'd9, 32'h0000_0999, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (pending[9] !== 1'b0) begin
            errors++;
            $display("FAIL clear9: pending9=%b, expected 0", pending[9]);
        end
        idle(5'd0, 5'd0);
    endtask

    task automatic test_rd_zero();
        cycle(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_ga !== 1'b1 || obs_stall !== 1'b0) begin
            errors++;
            $display("FAIL rd0_ready: a_ready=%b stall=%b, expected 1 0", obs_ga, obs_stall);
        end
        checks++;
        if (we !== 1'b0 || pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL rd0_we: we=%b pending0=%b, expected 0 0", we, pending[0]);
        end
        idle(5'd0, 5'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom(),
                  $urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom(),
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 2; i++) idle(5'd0, 5'd0);
    endtask

    task automatic test_reset_mid();
        // Drain anything left pending from earlier traffic.
        for (int r = 1; r < 32; r++) begin
            if (m_pend[r]) cycle(1'b1, 5'(r), 32'(r), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        end
        for (int r = 8; r < 12; r++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 5'd0, 5'd0);
        end
        checks++;
        if (pending !== 32'h00000F00) begin
            errors++;
            $display("FAIL pend_f00: pending=%h, expected 00000f00", pending);
        end
        // Move priority to B so the reset visibly restores it.
        if (m_ptr == 1'b0) cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b0, 5'd0, 5'd0, 5'd0);
        clrn = 1'b0;
        cycle(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_ga !== 1'b0 || obs_gb !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b, expected 0 0", obs_ga, obs_gb);
        end
        checks++;
        if (pending !== 32'd0 || we !== 1'b0 || wn !== 5'd0 || d !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: pending=%h we=%b wn=%0d d=%h, expected 0", pending, we, wn, d);
        end
        clrn = 1'b1;
        idle(5'd0, 5'd0);
        cycle(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_ga !== 1'b1 || obs_gb !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptr: a_ready=%b b_ready=%b, expected 1 0", obs_ga, obs_gb);
        end
        idle(5'd0, 5'd0);
    endtask

    initial begin
        clrn = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        issue_we = 1'b0; issue_rd = '0; rs = '0; rt = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_set_wins();
        test_rd_zero();
        test_random();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected writes never observed", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter: RR_INIT, default 0, round-robin pointer value after reset (0 = requester A favoured first, 1 = B).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clrn  input  1  reset, synchronous, active-low.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_rd  input  5  requester A destination register.
REQ-006 a_data  input  32  requester A write data.
REQ-007 a_ready  output  1  A accepted this cycle; combinational.
REQ-008 b_valid, b_rd, b_data, b_ready  in/in/in/out  1/5/32/1  same as A, for requester B (load/multicycle unit).
REQ-009 issue_we  input  1  decode issued an instruction that will write issue_rd.
REQ-010 issue_rd  input  5  destination of the issued instruction.
REQ-011 rs, rt  input  5 each  source registers of the instruction in decode.
REQ-012 stall  output  1  decode must hold; combinational.
REQ-013 wn  output  5  register file write address; registered.
REQ-014 d  output  32  register file write data; registered.
REQ-015 we  output  1  register file write enable; registered.
REQ-016 pending  output  32  scoreboard, bit i = write to ri outstanding; bit 0 always 0.

Function
REQ-017 Transfer on a requester occurs when valid and ready are both 1 at a rising edge; at most one transfer per cycle.
REQ-018 Arbitration: only one valid -> that one granted; both valid -> requester selected by pointer granted; ready never asserted without own valid.
REQ-019 Pointer toggles to the non-granted requester only when both were valid and a transfer occurred; otherwise holds.
REQ-020 Latency: transfer at edge N drives wn/d from the winner and we=1 for exactly cycle N..N+1; no transfer -> we=0, wn/d hold previous values.
REQ-021 Transfer with rd=0 is accepted (ready=1) but yields we=0.
REQ-022 pending[issue_rd] set at edge when issue_we=1, stall=0 and issue_rd!=0.
REQ-023 pending[rd] of the transferred request cleared at the transfer edge.
REQ-024 Set and clear of the same register at the same edge: set wins (bit ends 1).
REQ-025 stall = (rs!=0 and pending[rs]) or (rt!=0 and pending[rt]); issue_rd ignored while stall=1.
REQ-026 Transfer to a register not pending is legal; clear is no-op, write still performed.
REQ-027 Requester may hold valid with changing rd/data; no data captured until transfer.

Reset
REQ-028 clrn=0 at a rising edge: pending=0, we=0, wn=0, d=0, pointer=RR_INIT; ready outputs forced 0 while clrn=0.
REQ-029 Reset mid-operation discards any in-flight grant and all pending bits; no write issued in the cycle after reset release unless a transfer occurs on that edge.

Structure
REQ-030 Shared package regfile_pkg holds REG_ADDR_W=5, DATA_W=32, requester-id enum {REQ_A, REQ_B}.
REQ-031 One sub-module rr_arb2: two-input round-robin arbiter with pointer register, producing grant vector; scoreboard and write-port register stay in top.

Verification
REQ-032 Reset, a_valid=1 rd=5 data=0x11111111 -> a_ready=1, next cycle wn=5 d=0x11111111 we=1, following cycle we=0.
REQ-033 Both valid each cycle (A rd=3, B rd=4), RR_INIT=0 -> grants A,B,A,B alternating; we=1 every cycle after first.
REQ-034 issue_we rd=7, then rs=7 -> stall=1 until B transfers rd=7; stall=0 cycle after transfer edge.
REQ-035 Same edge: issue_we rd=9 and A transfer rd=9 -> pending[9]=1 afterwards.
REQ-036 A transfer rd=0 data=0xDEADBEEF -> a_ready=1, we stays 0; rs=0 never stalls.
REQ-037 clrn=0 while pending=0x00000F00 and both valid -> next cycle pending=0, we=0, ready=0, pointer=RR_INIT.
